// File: rtl/trace_axis_width_downsizer_if.sv
// AXI-Stream bundle used on both sides of the trace width downsizer.
// WIDTH sets the tdata width of this particular link.
interface trace_axis_width_downsizer_if #(
    parameter int WIDTH = 64
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;
    logic             tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/trace_axis_width_downsizer.sv
// Trace packet width downsizer.
// Holds one wide trace packet and emits it as BEATS narrow AXI-Stream beats,
// least-significant slice first. A new packet can be accepted on the
// handshake of the final beat, so back-to-back packets leave no bubble.
// Also counts forwarded packets and output back-pressure stall cycles.
module trace_axis_width_downsizer #(
    parameter int IN_WIDTH  = 1024,
    parameter int OUT_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    trace_axis_width_downsizer_if.slave         S_AXIS,
    trace_axis_width_downsizer_if.master        M_AXIS,
    output logic [31:0]                         pkt_count,
    output logic [31:0]                         stall_count,
    input  logic                                clr_counters
);

    localparam int BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || BEATS < 1) begin : g_bad_width
            $error("IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   beat_idx_q, beat_idx_d;
    logic [BEATS-1:0][OUT_WIDTH-1:0]    hold_q, hold_d;
    logic                               tlast_q, tlast_d;
    logic [31:0]                        pkt_count_q, pkt_count_d;
    logic [31:0]                        stall_count_q, stall_count_d;

    logic last_beat;
    logic s_ready;
    logic s_hs;
    logic m_hs;
    logic pkt_done;

    // Handshake decode; input ready only frees up on the last beat's handshake.
    always_comb begin
        last_beat = (beat_idx_q == LAST_IDX);
        s_ready   = (state_q == IDLE) ||
                    ((state_q == SEND) && last_beat && M_AXIS.tready);
        s_hs      = S_AXIS.tvalid && s_ready;
        m_hs      = (state_q == SEND) && M_AXIS.tready;
        pkt_done  = m_hs && last_beat;
    end

    // Next-state logic: latch packets, step through beats, chain packets without a bubble.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        hold_d     = hold_q;
        tlast_d    = tlast_q;
        case (state_q)
            IDLE: begin
                if (s_hs) begin
                    hold_d     = S_AXIS.tdata;
                    tlast_d    = S_AXIS.tlast;
                    beat_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (m_hs) begin
                    if (!last_beat) begin
                        beat_idx_d = beat_idx_q + IDX_W'(1);
                    end else if (s_hs) begin
                        hold_d     = S_AXIS.tdata;
                        tlast_d    = S_AXIS.tlast;
                        beat_idx_d = '0;
                    end else begin
                        beat_idx_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_idx_d = '0;
            end
        endcase
    end

    // Statistics counters; a clear beats a same-cycle increment, both wrap at 2^32.
    always_comb begin
        pkt_count_d   = pkt_count_q;
        stall_count_d = stall_count_q;
        if (clr_counters) begin
            pkt_count_d   = '0;
            stall_count_d = '0;
        end else begin
            if (pkt_done) begin
                pkt_count_d = pkt_count_q + 32'd1;
            end
            if ((state_q == SEND) && !M_AXIS.tready) begin
                stall_count_d = stall_count_q + 32'd1;
            end
        end
    end

    // State, hold and counter registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_idx_q    <= '0;
            hold_q        <= '0;
            tlast_q       <= 1'b0;
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            beat_idx_q    <= beat_idx_d;
            hold_q        <= hold_d;
            tlast_q       <= tlast_d;
            pkt_count_q   <= pkt_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign S_AXIS.tready = s_ready;
    assign M_AXIS.tvalid = (state_q == SEND);
    assign M_AXIS.tdata  = hold_q[beat_idx_q];
    assign M_AXIS.tlast  = (state_q == SEND) && tlast_q && last_beat;
    assign pkt_count     = pkt_count_q;
    assign stall_count   = stall_count_q;

endmodule
